mem_port_arbiter: RTL and testbench

//  Shares the single data_mem port between the MEM stage (core) and an external loader/debug master (ext).

---
 rtl/mem_port_arbiter_pkg.sv | 25 ++
 rtl/mem_port_arbiter_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared owner/state codes and helpers for the data_mem port arbiter.
// Build option: MEM_ARB_FAIR_EN enables the ext anti-starvation counter.
`ifndef LAPIDO_DEFS
`define LAPIDO_DEFS
`define ARB_OWN_NONE 2'b00
`define ARB_OWN_CORE 2'b01
`define ARB_OWN_EXT  2'b10
`define ARB_ST_IDLE  2'b00
`define ARB_ST_CORE  2'b01
`define ARB_ST_EXT   2'b10
`endif

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `ARB_ST_IDLE,
    ST_CORE = `ARB_ST_CORE,
    ST_EXT  = `ARB_ST_EXT
  } arb_state_e;

  function automatic int cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_counter.sv
// Saturating event counter with clear and limit flag.
// Build option: none (used by mem_port_arbiter, MEM_ARB_FAIR_EN aware top).
module arb_sat_counter #(
  parameter int W     = 4,
  parameter int LIMIT = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  assign at_limit = (cnt == W'(LIMIT));

  // clr with inc restarts the count at one (a new run begins this cycle)
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= inc ? W'(1) : '0;
    end else if (inc && !at_limit) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data_mem port shared between MEM stage (core) and ext master.
// Build option: MEM_ARB_FAIR_EN forces ext in after STARVE_LIMIT denials.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int EXT_MAX_BURST = 8,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [DATA_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_stall,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_rvalid,
  input  logic                  ext_req,
  input  logic                  ext_we,
  input  logic                  ext_lock,
  input  logic [DATA_WIDTH-1:0] ext_addr,
  input  logic [DATA_WIDTH-1:0] ext_wdata,
  output logic                  ext_gnt,
  output logic [DATA_WIDTH-1:0] ext_rdata,
  output logic                  ext_rvalid,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            owner
);

  localparam int BW = cnt_w(EXT_MAX_BURST);

  arb_state_e state_q, state_d;
  logic g_core, g_ext;
  logic burst_at, fair_take;
  logic [BW-1:0] burst_cnt;
  logic rd_core_q, rd_ext_q;
  logic [DATA_WIDTH-1:0] core_hold_q, ext_hold_q;

  arb_sat_counter #(.W(BW), .LIMIT(EXT_MAX_BURST)) u_burst (
    .clk      (clk),
    .rst      (rst),
    .clr      (~g_ext | burst_at),
    .inc      (g_ext),
    .cnt      (burst_cnt),
    .at_limit (burst_at)
  );

`ifdef MEM_ARB_FAIR_EN
  localparam int SW = cnt_w(STARVE_LIMIT);
  logic [SW-1:0] starve_cnt;
  logic starve_at;

  arb_sat_counter #(.W(SW), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (g_ext),
    .inc      (ext_req & ~g_ext),
    .cnt      (starve_cnt),
    .at_limit (starve_at)
  );

  assign fair_take = ext_req & starve_at;
`else
  assign fair_take = 1'b0;
`endif

  always_comb begin
    g_core  = 1'b0;
    g_ext   = 1'b0;
    state_d = ST_IDLE;
    if (rst) begin
      if (state_q == ST_EXT && ext_req && ext_lock && !burst_at)
        g_ext = 1'b1;
      else if (fair_take)
        g_ext = 1'b1;
      else if (core_req)
        g_core = 1'b1;
      else if (ext_req)
        g_ext = 1'b1;
    end
    unique case (1'b1)
      g_core:  state_d = ST_CORE;
      g_ext:   state_d = ST_EXT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_core_q   <= 1'b0;
      rd_ext_q    <= 1'b0;
      core_hold_q <= '0;
      ext_hold_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_core_q <= g_core & ~core_we;
      rd_ext_q  <= g_ext & ~ext_we;
      if (rd_core_q) core_hold_q <= mem_rdata;
      if (rd_ext_q)  ext_hold_q  <= mem_rdata;
    end
  end

  assign mem_addr  = g_core ? core_addr  : (g_ext ? ext_addr  : '0);
  assign mem_wdata = g_core ? core_wdata : (g_ext ? ext_wdata : '0);
  assign mem_we    = (g_core & core_we) | (g_ext & ext_we);
  assign owner     = g_core ? `ARB_OWN_CORE :
                     (g_ext ? `ARB_OWN_EXT : `ARB_OWN_NONE);

  assign core_stall = rst & core_req & ~g_core;
  assign ext_gnt    = g_ext;

  // an in-flight return is dropped as soon as reset is seen
  assign core_rvalid = rst & rd_core_q;
  assign ext_rvalid  = rst & rd_ext_q;
  assign core_rdata  = rd_core_q ? mem_rdata : core_hold_q;
  assign ext_rdata   = rd_ext_q  ? mem_rdata : ext_hold_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Build option: MEM_ARB_FAIR_EN changes the fairness expectations.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req, core_we;
  logic [31:0] core_addr, core_wdata;
  logic        core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        ext_req, ext_we, ext_lock;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // memory model: read data is a fixed function of the address, one cycle late
  always @(posedge clk) mem_rdata <= mem_addr ^ 32'hA5A5_0000;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we),
    .core_addr(core_addr), .core_wdata(core_wdata),
    .core_stall(core_stall), .core_rdata(core_rdata),
    .core_rvalid(core_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .owner(owner)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    core_req = 0; core_we = 0; core_addr = 0; core_wdata = 0;
    ext_req = 0; ext_we = 0; ext_lock = 0; ext_addr = 0; ext_wdata = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    core_req = 1; core_we = 1; core_addr = 32'h8; core_wdata = 32'h55;
    ext_req = 1; ext_we = 1; ext_addr = 32'hC; ext_wdata = 32'h66;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); @(negedge clk); checks++;
      if ({core_stall, ext_gnt, mem_we, owner, core_rvalid, ext_rvalid}
          !== 7'b0 || mem_addr !== 0 || mem_wdata !== 0) begin
        errors++;
        $display("FAIL reset[%0d]: stall=%b gnt=%b we=%b own=%b addr=%h want all 0",
                 i, core_stall, ext_gnt, mem_we, owner, mem_addr);
      end
    end
    checks++;
    if (core_rdata !== 0 || ext_rdata !== 0) begin
      errors++;
      $display("FAIL reset_rdata: core=%h ext=%h want 0", core_rdata, ext_rdata);
    end
    #1; idle_inputs(); rst = 1;
    next_cycle();
  endtask

  task automatic test_conflict();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    ext_req = 1; ext_we = 1; ext_addr = 32'h20; ext_wdata = 32'hDEAD;
    @(negedge clk); checks++;
    if ({core_stall, ext_gnt, mem_we, owner} !== 5'b00001 || mem_addr !== 32'h10) begin
      errors++;
      $display("FAIL conflict_c1: stall=%b gnt=%b we=%b own=%b addr=%h want 0 0 0 01 10",
               core_stall, ext_gnt, mem_we, owner, mem_addr);
    end
    next_cycle();
    core_req = 0;
    @(negedge clk); checks++;
    if ({ext_gnt, mem_we, owner} !== 4'b1110 || mem_addr !== 32'h20
        || mem_wdata !== 32'hDEAD) begin
      errors++;
      $display("FAIL conflict_c2: gnt=%b we=%b own=%b addr=%h wd=%h want 1 1 10 20 dead",
               ext_gnt, mem_we, owner, mem_addr, mem_wdata);
    end
    checks++;
    if (core_rvalid !== 1 || core_rdata !== 32'hA5A5_0010) begin
      errors++;
      $display("FAIL conflict_rdata: rvalid=%b rdata=%h want 1 a5a50010",
               core_rvalid, core_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk); checks++;
    if (ext_rvalid !== 0 || core_rvalid !== 0 || owner !== 2'b00) begin
      errors++;
      $display("FAIL conflict_wr_norvalid: ext_rvalid=%b core_rvalid=%b own=%b want 0 0 00",
               ext_rvalid, core_rvalid, owner);
    end
    next_cycle();
  endtask

  task automatic test_lock_burst();
    for (int i = 1; i <= 12; i++) begin
      ext_req = 1; ext_lock = 1; ext_we = 1; ext_addr = 32'h100 + i;
      core_req = (i >= 2); core_we = 1; core_addr = 32'h200 + i;
      @(negedge clk); checks++;
      if (ext_gnt !== (i <= 8) || core_stall !== (i >= 2 && i <= 8)
          || owner !== ((i <= 8) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL lock_burst[%0d]: gnt=%b stall=%b own=%b want %b %b %b",
                 i, ext_gnt, core_stall, owner, (i <= 8),
                 (i >= 2 && i <= 8), (i <= 8) ? 2'b10 : 2'b01);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_read_routing();
    ext_req = 1; ext_we = 0; ext_addr = 32'h40;
    @(negedge clk); checks++;
    if (ext_gnt !== 1 || mem_we !== 0 || mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL route_ext_gnt: gnt=%b we=%b addr=%h want 1 0 40",
               ext_gnt, mem_we, mem_addr);
    end
    next_cycle();
    ext_req = 0; core_req = 1; core_we = 0; core_addr = 32'h44;
    @(negedge clk); checks++;
    if ({ext_rvalid, core_rvalid, core_stall} !== 3'b100
        || ext_rdata !== 32'hA5A5_0040) begin
      errors++;
      $display("FAIL route_ext_ret: ev=%b cv=%b stall=%b erd=%h want 1 0 0 a5a50040",
               ext_rvalid, core_rvalid, core_stall, ext_rdata);
    end
    next_cycle();
    idle_inputs();
    @(negedge clk); checks++;
    if ({ext_rvalid, core_rvalid} !== 2'b01 || core_rdata !== 32'hA5A5_0044
        || ext_rdata !== 32'hA5A5_0040) begin
      errors++;
      $display("FAIL route_core_ret: ev=%b cv=%b crd=%h erd=%h want 0 1 a5a50044 a5a50040",
               ext_rvalid, core_rvalid, core_rdata, ext_rdata);
    end
    next_cycle();
  endtask

  task automatic test_fairness();
    bit exp;
    core_req = 1; core_we = 1; core_addr = 32'h300;
    ext_req = 1; ext_we = 1; ext_addr = 32'h400;
    for (int i = 1; i <= 10; i++) begin
`ifdef MEM_ARB_FAIR_EN
      exp = (i % 5 == 0);
`else
      exp = 1'b0;
`endif
      @(negedge clk); checks++;
      if (ext_gnt !== exp || core_stall !== exp) begin
        errors++;
        $display("FAIL fairness[%0d]: gnt=%b stall=%b want %b %b",
                 i, ext_gnt, core_stall, exp, exp);
      end
      next_cycle();
    end
    idle_inputs();
    next_cycle();
  endtask

  task automatic test_mid_read_reset();
    core_req = 1; core_we = 0; core_addr = 32'h10;
    @(negedge clk); checks++;
    if (owner !== 2'b01 || core_stall !== 0) begin
      errors++;
      $display("FAIL midrst_gnt: own=%b stall=%b want 01 0", owner, core_stall);
    end
    next_cycle();
    rst = 0;
    @(negedge clk); checks++;
    if ({core_rvalid, core_stall, owner} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_drop: rvalid=%b stall=%b own=%b want 0 0 00",
               core_rvalid, core_stall, owner);
    end
    next_cycle();
    rst = 1; core_req = 0;
    @(negedge clk); checks++;
    if (core_rvalid !== 0 || ext_rvalid !== 0) begin
      errors++;
      $display("FAIL midrst_after: cv=%b ev=%b want 0 0", core_rvalid, ext_rvalid);
    end
    next_cycle();
  endtask

  initial begin
    idle_inputs();
    rst = 0;
    test_reset();
    test_conflict();
    test_lock_burst();
    test_read_routing();
    test_fairness();
    test_mid_read_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
